// File: rtl/vx_smem_responder_if.sv
// Per-lane D-cache request/response bundle between an LSU (master) and a
// memory responder (slave).
interface vx_smem_responder_if #(
    parameter int unsigned NUM_REQS   = 4,
    parameter int unsigned ADDR_WIDTH = 30,
    parameter int unsigned TAG_WIDTH  = 16
);
    logic [NUM_REQS-1:0]            req_valid;
    logic [NUM_REQS-1:0]            req_rw;
    logic [NUM_REQS*ADDR_WIDTH-1:0] req_addr;
    logic [NUM_REQS*4-1:0]          req_byteen;
    logic [NUM_REQS*32-1:0]         req_data;
    logic [NUM_REQS*TAG_WIDTH-1:0]  req_tag;
    logic [NUM_REQS-1:0]            req_ready;

    logic                           rsp_valid;
    logic [NUM_REQS-1:0]            rsp_tmask;
    logic [NUM_REQS*32-1:0]         rsp_data;
    logic [TAG_WIDTH-1:0]           rsp_tag;
    logic                           rsp_ready;

    modport master (
        output req_valid, req_rw, req_addr, req_byteen, req_data, req_tag, rsp_ready,
        input  req_ready, rsp_valid, rsp_tmask, rsp_data, rsp_tag
    );

    modport slave (
        input  req_valid, req_rw, req_addr, req_byteen, req_data, req_tag, rsp_ready,
        output req_ready, rsp_valid, rsp_tmask, rsp_data, rsp_tag
    );
endinterface

// File: rtl/vx_smem_responder.sv
// Banked scratchpad responder: one lane per bank per cycle, restricted to the
// tag of the lowest valid lane; loads return one merged tagged response.
module vx_smem_responder #(
    parameter int unsigned NUM_REQS   = 4,
    parameter int unsigned NUM_BANKS  = 4,
    parameter int unsigned SIZE       = 16384,
    parameter int unsigned ADDR_WIDTH = 30,
    parameter int unsigned TAG_WIDTH  = 16
) (
    input logic                clk,
    input logic                reset,
    vx_smem_responder_if.slave bus
);
    localparam int unsigned Words    = SIZE / 4;
    localparam int unsigned Rows     = Words / NUM_BANKS;
    localparam int unsigned BankBits = $clog2(NUM_BANKS);
    localparam int unsigned RowBits  = $clog2(Rows);
    localparam int unsigned BankW    = (BankBits > 0) ? BankBits : 1;
    localparam int unsigned RowW     = (RowBits > 0) ? RowBits : 1;

    logic [TAG_WIDTH-1:0] lane_tag  [NUM_REQS];
    logic [BankW-1:0]     lane_bank [NUM_REQS];
    logic [RowW-1:0]      lane_row  [NUM_REQS];

    // Upper address bits are dropped so accesses wrap modulo SIZE.
    for (genvar i = 0; i < NUM_REQS; i++) begin : g_lane
        assign lane_tag[i] = bus.req_tag[i*TAG_WIDTH +: TAG_WIDTH];
        if (BankBits == 0) begin : g_single_bank
            assign lane_bank[i] = '0;
        end else begin : g_multi_bank
            assign lane_bank[i] = bus.req_addr[i*ADDR_WIDTH +: BankW];
        end
        if (RowBits == 0) begin : g_single_row
            assign lane_row[i] = '0;
        end else begin : g_multi_row
            assign lane_row[i] = bus.req_addr[i*ADDR_WIDTH+BankBits +: RowW];
        end
    end

    logic                 rsp_valid_q, rsp_valid_d;
    logic [NUM_REQS-1:0]  rsp_tmask_q, rsp_tmask_d;
    logic [TAG_WIDTH-1:0] rsp_tag_q, rsp_tag_d;
    logic [BankW-1:0]     rsp_bank_q [NUM_REQS];
    logic [BankW-1:0]     rsp_bank_d [NUM_REQS];

    logic [TAG_WIDTH-1:0] batch_tag;
    logic [NUM_REQS-1:0]  eligible;
    logic [NUM_REQS-1:0]  grant;
    logic [NUM_REQS-1:0]  fire;
    logic [NUM_REQS-1:0]  load_fire;
    logic                 stall;

    assign stall = rsp_valid_q & ~bus.rsp_ready;

    always_comb begin
        batch_tag = '0;
        eligible  = '0;
        grant     = '0;
        // Walk downwards so the lowest valid lane's tag is the last one kept.
        for (int i = NUM_REQS - 1; i >= 0; i--) begin
            if (bus.req_valid[i]) batch_tag = lane_tag[i];
        end
        for (int i = 0; i < NUM_REQS; i++) begin
            eligible[i] = bus.req_valid[i] && (lane_tag[i] == batch_tag);
        end
        for (int i = 0; i < NUM_REQS; i++) begin
            grant[i] = eligible[i];
            for (int j = 0; j < NUM_REQS; j++) begin
                if (j < i && eligible[j] && lane_bank[j] == lane_bank[i]) grant[i] = 1'b0;
            end
        end
    end

    assign fire          = grant & {NUM_REQS{~stall & ~reset}};
    assign load_fire     = fire & ~bus.req_rw;
    assign bus.req_ready = fire;

    logic [NUM_BANKS-1:0] bank_rd;
    logic [NUM_BANKS-1:0] bank_wr;
    logic [RowW-1:0]      bank_row   [NUM_BANKS];
    logic [3:0]           bank_be    [NUM_BANKS];
    logic [31:0]          bank_wdata [NUM_BANKS];

    // Arbitration guarantees at most one fired lane per bank.
    always_comb begin
        bank_rd = '0;
        bank_wr = '0;
        for (int b = 0; b < NUM_BANKS; b++) begin
            bank_row[b]   = '0;
            bank_be[b]    = '0;
            bank_wdata[b] = '0;
        end
        for (int i = 0; i < NUM_REQS; i++) begin
            if (fire[i]) begin
                bank_row[lane_bank[i]]   = lane_row[i];
                bank_rd[lane_bank[i]]    = ~bus.req_rw[i];
                bank_wr[lane_bank[i]]    = bus.req_rw[i];
                bank_be[lane_bank[i]]    = bus.req_byteen[i*4 +: 4];
                bank_wdata[lane_bank[i]] = bus.req_data[i*32 +: 32];
            end
        end
    end

    logic [31:0] mem [NUM_BANKS][Rows];
    logic [31:0] bank_rdata_q [NUM_BANKS];

    always_ff @(posedge clk) begin
        for (int b = 0; b < NUM_BANKS; b++) begin
            if (bank_wr[b]) begin
                for (int k = 0; k < 4; k++) begin
                    if (bank_be[b][k]) mem[b][bank_row[b]][k*8 +: 8] <= bank_wdata[b][k*8 +: 8];
                end
            end
        end
    end

    always_ff @(posedge clk) begin
        for (int b = 0; b < NUM_BANKS; b++) begin
            if (reset) begin
                bank_rdata_q[b] <= '0;
            end else if (bank_rd[b]) begin
                bank_rdata_q[b] <= mem[b][bank_row[b]];
            end
        end
    end

    always_comb begin
        rsp_valid_d = rsp_valid_q;
        rsp_tmask_d = rsp_tmask_q;
        rsp_tag_d   = rsp_tag_q;
        for (int i = 0; i < NUM_REQS; i++) rsp_bank_d[i] = rsp_bank_q[i];
        if (|load_fire) begin
            rsp_valid_d = 1'b1;
            rsp_tmask_d = load_fire;
            rsp_tag_d   = batch_tag;
            for (int i = 0; i < NUM_REQS; i++) rsp_bank_d[i] = lane_bank[i];
        end else if (bus.rsp_ready) begin
            rsp_valid_d = 1'b0;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            rsp_valid_q <= 1'b0;
            rsp_tmask_q <= '0;
            rsp_tag_q   <= '0;
            for (int i = 0; i < NUM_REQS; i++) rsp_bank_q[i] <= '0;
        end else begin
            rsp_valid_q <= rsp_valid_d;
            rsp_tmask_q <= rsp_tmask_d;
            rsp_tag_q   <= rsp_tag_d;
            for (int i = 0; i < NUM_REQS; i++) rsp_bank_q[i] <= rsp_bank_d[i];
        end
    end

    always_comb begin
        bus.rsp_data = '0;
        for (int i = 0; i < NUM_REQS; i++) begin
            bus.rsp_data[i*32 +: 32] = bank_rdata_q[rsp_bank_q[i]];
        end
    end

    assign bus.rsp_valid = rsp_valid_q;
    assign bus.rsp_tmask = rsp_tmask_q;
    assign bus.rsp_tag   = rsp_tag_q;
endmodule

// File: tb/tb_vx_smem_responder.sv
// Scoreboard bench for vx_smem_responder: a word-memory model predicts each
// load response as lanes fire; responses are popped and compared on arrival.
module tb_vx_smem_responder;
    localparam int NR    = 4;
    localparam int AW    = 30;
    localparam int TW    = 16;
    localparam int SIZE  = 16384;
    localparam int WORDS = SIZE / 4;

    logic clk = 1'b0;
    logic reset = 1'b1;
    always #5 clk = ~clk;

    vx_smem_responder_if #(.NUM_REQS(NR), .ADDR_WIDTH(AW), .TAG_WIDTH(TW)) bus ();

    vx_smem_responder #(
        .NUM_REQS(NR), .NUM_BANKS(4), .SIZE(SIZE), .ADDR_WIDTH(AW), .TAG_WIDTH(TW)
    ) dut (
        .clk  (clk),
        .reset(reset),
        .bus  (bus)
    );

    typedef struct {
        logic [NR-1:0]    tmask;
        logic [TW-1:0]    tag;
        logic [NR*32-1:0] data;
    } rsp_t;

    rsp_t        sb[$];
    logic [31:0] model_mem [int];
    int          vectors = 0;
    int          miscompares = 0;

    function automatic logic [31:0] mread(input int a);
        return model_mem.exists(a) ? model_mem[a] : 32'h0;
    endfunction

    function automatic logic [NR*32-1:0] lane_mask(input logic [NR-1:0] m);
        logic [NR*32-1:0] r = '0;
        for (int i = 0; i < NR; i++) if (m[i]) r[i*32 +: 32] = 32'hFFFF_FFFF;
        return r;
    endfunction

    task automatic drive(input int i, input logic v, input logic rw, input logic [AW-1:0] a,
                         input logic [3:0] be, input logic [31:0] d, input logic [TW-1:0] t);
        bus.req_valid[i]           = v;
        bus.req_rw[i]              = rw;
        bus.req_addr[i*AW +: AW]   = a;
        bus.req_byteen[i*4 +: 4]   = be;
        bus.req_data[i*32 +: 32]   = d;
        bus.req_tag[i*TW +: TW]    = t;
    endtask

    task automatic clear_reqs();
        bus.req_valid  = '0;
        bus.req_rw     = '0;
        bus.req_addr   = '0;
        bus.req_byteen = '0;
        bus.req_data   = '0;
        bus.req_tag    = '0;
    endtask

    // Apply the expected grant to the model, queue any load response, cross the edge.
    task automatic fire_cycle(input logic [NR-1:0] granted);
        rsp_t e;
        e.tmask = '0;
        e.tag   = '0;
        e.data  = '0;
        for (int i = 0; i < NR; i++) begin
            if (granted[i] && !bus.req_rw[i]) begin
                e.tmask[i]          = 1'b1;
                e.tag               = bus.req_tag[i*TW +: TW];
                e.data[i*32 +: 32]  = mread(int'(bus.req_addr[i*AW +: AW]) % WORDS);
            end
        end
        for (int i = 0; i < NR; i++) begin
            if (granted[i] && bus.req_rw[i]) begin
                int a;
                logic [31:0] w;
                a = int'(bus.req_addr[i*AW +: AW]) % WORDS;
                w = mread(a);
                for (int k = 0; k < 4; k++)
                    if (bus.req_byteen[i*4 + k]) w[k*8 +: 8] = bus.req_data[i*32 + k*8 +: 8];
                model_mem[a] = w;
            end
        end
        if (e.tmask != '0) sb.push_back(e);
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        @(negedge clk);
        clear_reqs();
        drive(0, 1'b1, 1'b0, 30'd0, 4'h0, 32'h0, 16'd3);
        #1;
        vectors++;
        if (bus.req_ready !== 4'b0000) begin
            miscompares++;
            $display("FAIL reset_ready: got %b want 0000", bus.req_ready);
        end
        @(posedge clk);
        #1;
        vectors++;
        if (bus.rsp_valid !== 1'b0 || bus.rsp_tmask !== 4'b0 || bus.rsp_tag !== 16'h0 ||
            bus.rsp_data !== 128'h0) begin
            miscompares++;
            $display("FAIL reset_rsp: got v=%b m=%b t=%h d=%h want all zero",
                     bus.rsp_valid, bus.rsp_tmask, bus.rsp_tag, bus.rsp_data);
        end
        @(negedge clk);
        clear_reqs();
        reset = 1'b0;
    endtask

    task automatic test_store_load();
        rsp_t e;
        @(negedge clk);
        for (int i = 0; i < NR; i++) drive(i, 1'b1, 1'b1, AW'(i), 4'hF, 32'hA0 + i, 16'd5);
        #1;
        vectors++;
        if (bus.req_ready !== 4'b1111) begin
            miscompares++;
            $display("FAIL store_ready: got %b want 1111", bus.req_ready);
        end
        fire_cycle(4'b1111);
        vectors++;
        if (bus.rsp_valid !== 1'b0) begin
            miscompares++;
            $display("FAIL store_no_rsp: got rsp_valid=%b want 0", bus.rsp_valid);
        end
        @(negedge clk);
        for (int i = 0; i < NR; i++) drive(i, 1'b1, 1'b0, AW'(i), 4'h0, 32'h0, 16'd6);
        #1;
        vectors++;
        if (bus.req_ready !== 4'b1111) begin
            miscompares++;
            $display("FAIL load_ready: got %b want 1111", bus.req_ready);
        end
        fire_cycle(4'b1111);
        e = sb.pop_front();
        vectors++;
        if (bus.rsp_valid !== 1'b1 || bus.rsp_tmask !== e.tmask || bus.rsp_tag !== e.tag ||
            (bus.rsp_data & lane_mask(e.tmask)) !== (e.data & lane_mask(e.tmask))) begin
            miscompares++;
            $display("FAIL load_rsp: got v=%b m=%b t=%h d=%h want v=1 m=%b t=%h d=%h",
                     bus.rsp_valid, bus.rsp_tmask, bus.rsp_tag, bus.rsp_data,
                     e.tmask, e.tag, e.data);
        end
        @(negedge clk);
        clear_reqs();
        fire_cycle(4'b0000);
        vectors++;
        if (bus.rsp_valid !== 1'b0) begin
            miscompares++;
            $display("FAIL rsp_clear: got rsp_valid=%b want 0", bus.rsp_valid);
        end
    endtask

    task automatic test_bank_conflict();
        logic [NR-1:0] grants [3];
        logic [NR-1:0] remaining;
        logic [AW-1:0] addrs [NR];
        rsp_t e;
        grants[0] = 4'b1001;
        grants[1] = 4'b0010;
        grants[2] = 4'b0100;
        addrs[0] = 30'd0;
        addrs[1] = 30'd4;
        addrs[2] = 30'd8;
        addrs[3] = 30'd1;
        for (int k = 0; k < 2; k++) begin
            @(negedge clk);
            for (int i = 0; i < NR; i++)
                drive(i, 1'b1, 1'b1, AW'(4 + 4*k + i), 4'hF, 32'hB0 + 32'(16*k + 4 + i), 16'd2);
            #1;
            vectors++;
            if (bus.req_ready !== 4'b1111) begin
                miscompares++;
                $display("FAIL preload_ready%0d: got %b want 1111", k, bus.req_ready);
            end
            fire_cycle(4'b1111);
        end
        remaining = 4'b1111;
        for (int c = 0; c < 3; c++) begin
            @(negedge clk);
            for (int i = 0; i < NR; i++) drive(i, remaining[i], 1'b0, addrs[i], 4'h0, 32'h0, 16'd7);
            #1;
            vectors++;
            if (bus.req_ready !== grants[c]) begin
                miscompares++;
                $display("FAIL conflict_ready%0d: got %b want %b", c, bus.req_ready, grants[c]);
            end
            fire_cycle(grants[c]);
            remaining = remaining & ~grants[c];
            e = sb.pop_front();
            vectors++;
            if (bus.rsp_valid !== 1'b1 || bus.rsp_tmask !== e.tmask || bus.rsp_tag !== e.tag ||
                (bus.rsp_data & lane_mask(e.tmask)) !== (e.data & lane_mask(e.tmask))) begin
                miscompares++;
                $display("FAIL conflict_rsp%0d: got v=%b m=%b t=%h d=%h want v=1 m=%b t=%h d=%h",
                         c, bus.rsp_valid, bus.rsp_tmask, bus.rsp_tag, bus.rsp_data,
                         e.tmask, e.tag, e.data);
            end
        end
        @(negedge clk);
        clear_reqs();
        fire_cycle(4'b0000);
    endtask

    task automatic test_mixed_tags();
        logic [NR-1:0] grants [2];
        rsp_t e;
        grants[0] = 4'b0001;
        grants[1] = 4'b0010;
        for (int c = 0; c < 2; c++) begin
            @(negedge clk);
            clear_reqs();
            if (c == 0) drive(0, 1'b1, 1'b0, 30'd0, 4'h0, 32'h0, 16'd1);
            drive(1, 1'b1, 1'b0, 30'd1, 4'h0, 32'h0, 16'd2);
            #1;
            vectors++;
            if (bus.req_ready !== grants[c]) begin
                miscompares++;
                $display("FAIL mixed_ready%0d: got %b want %b", c, bus.req_ready, grants[c]);
            end
            fire_cycle(grants[c]);
            e = sb.pop_front();
            vectors++;
            if (bus.rsp_valid !== 1'b1 || bus.rsp_tmask !== e.tmask || bus.rsp_tag !== e.tag ||
                (bus.rsp_data & lane_mask(e.tmask)) !== (e.data & lane_mask(e.tmask))) begin
                miscompares++;
                $display("FAIL mixed_rsp%0d: got v=%b m=%b t=%h d=%h want v=1 m=%b t=%h d=%h",
                         c, bus.rsp_valid, bus.rsp_tmask, bus.rsp_tag, bus.rsp_data,
                         e.tmask, e.tag, e.data);
            end
        end
        @(negedge clk);
        clear_reqs();
        fire_cycle(4'b0000);
    endtask

    task automatic test_byteen();
        rsp_t e;
        @(negedge clk);
        clear_reqs();
        drive(0, 1'b1, 1'b1, 30'd9, 4'hF, 32'h1122_3344, 16'd3);
        #1;
        fire_cycle(4'b0001);
        @(negedge clk);
        drive(0, 1'b1, 1'b1, AW'(9 + WORDS), 4'h6, 32'hFFFF_FFFF, 16'd3);
        #1;
        vectors++;
        if (bus.req_ready !== 4'b0001) begin
            miscompares++;
            $display("FAIL byteen_ready: got %b want 0001", bus.req_ready);
        end
        fire_cycle(4'b0001);
        for (int c = 0; c < 2; c++) begin
            @(negedge clk);
            clear_reqs();
            drive(c, 1'b1, 1'b0, (c == 0) ? 30'd9 : AW'(9 + WORDS), 4'h0, 32'h0, 16'd4);
            #1;
            fire_cycle(4'b0001 << c);
            e = sb.pop_front();
            vectors++;
            if (bus.rsp_valid !== 1'b1 || bus.rsp_tmask !== e.tmask ||
                bus.rsp_data[c*32 +: 32] !== 32'h11FF_FF44) begin
                miscompares++;
                $display("FAIL byteen_rsp%0d: got v=%b m=%b d=%h want v=1 m=%b d=11ffff44",
                         c, bus.rsp_valid, bus.rsp_tmask, bus.rsp_data[c*32 +: 32], e.tmask);
            end
        end
        @(negedge clk);
        clear_reqs();
        fire_cycle(4'b0000);
    endtask

    task automatic test_backpressure();
        rsp_t e;
        @(negedge clk);
        clear_reqs();
        bus.rsp_ready = 1'b1;
        drive(0, 1'b1, 1'b0, 30'd0, 4'h0, 32'h0, 16'd8);
        #1;
        fire_cycle(4'b0001);
        @(negedge clk);
        bus.rsp_ready = 1'b0;
        clear_reqs();
        drive(1, 1'b1, 1'b0, 30'd1, 4'h0, 32'h0, 16'd9);
        drive(2, 1'b1, 1'b1, 30'd2, 4'hF, 32'hD2, 16'd9);
        for (int k = 0; k < 3; k++) begin
            if (k > 0) @(negedge clk);
            #1;
            vectors++;
            if (bus.req_ready !== 4'b0000) begin
                miscompares++;
                $display("FAIL stall_ready%0d: got %b want 0000", k, bus.req_ready);
            end
            @(posedge clk);
            #1;
            vectors++;
            if (sb.size() == 0) begin
                miscompares++;
                $display("FAIL stall_rsp%0d: got empty scoreboard want one pending", k);
            end else if (bus.rsp_valid !== 1'b1 || bus.rsp_tmask !== sb[0].tmask ||
                         bus.rsp_tag !== sb[0].tag ||
                         (bus.rsp_data & lane_mask(sb[0].tmask)) !==
                         (sb[0].data & lane_mask(sb[0].tmask))) begin
                miscompares++;
                $display("FAIL stall_rsp%0d: got v=%b m=%b t=%h d=%h want v=1 m=%b t=%h d=%h",
                         k, bus.rsp_valid, bus.rsp_tmask, bus.rsp_tag, bus.rsp_data,
                         sb[0].tmask, sb[0].tag, sb[0].data);
            end
        end
        @(negedge clk);
        bus.rsp_ready = 1'b1;
        #1;
        vectors++;
        if (bus.req_ready !== 4'b0110) begin
            miscompares++;
            $display("FAIL unstall_ready: got %b want 0110", bus.req_ready);
        end
        void'(sb.pop_front());
        fire_cycle(4'b0110);
        e = sb.pop_front();
        vectors++;
        if (bus.rsp_valid !== 1'b1 || bus.rsp_tmask !== e.tmask || bus.rsp_tag !== e.tag ||
            (bus.rsp_data & lane_mask(e.tmask)) !== (e.data & lane_mask(e.tmask))) begin
            miscompares++;
            $display("FAIL unstall_rsp: got v=%b m=%b t=%h d=%h want v=1 m=%b t=%h d=%h",
                     bus.rsp_valid, bus.rsp_tmask, bus.rsp_tag, bus.rsp_data,
                     e.tmask, e.tag, e.data);
        end
        @(negedge clk);
        clear_reqs();
        fire_cycle(4'b0000);
    endtask

    task automatic test_reset_mid_op();
        rsp_t e;
        @(negedge clk);
        clear_reqs();
        drive(0, 1'b1, 1'b0, 30'd0, 4'h0, 32'h0, 16'd4);
        #1;
        fire_cycle(4'b0001);
        @(negedge clk);
        bus.rsp_ready = 1'b0;
        reset = 1'b1;
        clear_reqs();
        drive(1, 1'b1, 1'b0, 30'd1, 4'h0, 32'h0, 16'd4);
        #1;
        vectors++;
        if (bus.req_ready !== 4'b0000) begin
            miscompares++;
            $display("FAIL midreset_ready: got %b want 0000", bus.req_ready);
        end
        @(posedge clk);
        #1;
        sb.delete();
        vectors++;
        if (bus.rsp_valid !== 1'b0 || bus.rsp_tmask !== 4'b0000) begin
            miscompares++;
            $display("FAIL midreset_rsp: got v=%b m=%b want v=0 m=0000",
                     bus.rsp_valid, bus.rsp_tmask);
        end
        @(negedge clk);
        reset = 1'b0;
        bus.rsp_ready = 1'b1;
        #1;
        vectors++;
        if (bus.req_ready !== 4'b0010) begin
            miscompares++;
            $display("FAIL reissue_ready: got %b want 0010", bus.req_ready);
        end
        fire_cycle(4'b0010);
        e = sb.pop_front();
        vectors++;
        if (bus.rsp_valid !== 1'b1 || bus.rsp_tmask !== e.tmask || bus.rsp_tag !== e.tag ||
            (bus.rsp_data & lane_mask(e.tmask)) !== (e.data & lane_mask(e.tmask))) begin
            miscompares++;
            $display("FAIL reissue_rsp: got v=%b m=%b t=%h d=%h want v=1 m=%b t=%h d=%h",
                     bus.rsp_valid, bus.rsp_tmask, bus.rsp_tag, bus.rsp_data,
                     e.tmask, e.tag, e.data);
        end
        @(negedge clk);
        clear_reqs();
        fire_cycle(4'b0000);
    endtask

    initial begin
        clear_reqs();
        bus.rsp_ready = 1'b1;
        test_reset();
        test_store_load();
        test_bank_conflict();
        test_mixed_tags();
        test_byteen();
        test_backpressure();
        test_reset_mid_op();
        vectors++;
        if (sb.size() != 0) begin
            miscompares++;
            $display("FAIL scoreboard_drain: got %0d pending want 0", sb.size());
        end
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end
endmodule
